// File: rtl/nn_layer_scheduler_pkg.sv
// Shared types and width helpers for the layer scheduler and its arbiter.
package nn_layer_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Ceiling log2, never below 1 so that single-entry indices keep a legal width.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = 0;
      while ((64'd1 << bits) < 64'(value)) bits++;
      return (bits < 1) ? 1 : bits;
   endfunction

   // The timeout counter must be able to hold TIMEOUT_CYCLES itself.
   function automatic int timeout_cnt_width(input int timeout_cycles);
      return clog2_min1(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/nn_layer_scheduler_if.sv
// Host request, engine control and response signals between the scheduler and its surroundings.
interface nn_layer_scheduler_if
   import nn_layer_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int REQ_W   = clog2_min1(NUM_REQ),
   parameter int LAYER_W = 1
) ();

   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   logic               eng_start;
   logic [LAYER_W-1:0] eng_layer;
   logic               eng_relu_en;
   logic               eng_done;
   logic               buf_sel;
   logic               resp_valid;
   logic               resp_ready;
   logic [REQ_W-1:0]   resp_id;
   logic               resp_error;
   logic               busy;

   // Requesters, engine and response consumer.
   modport master (
      output req_valid, eng_done, resp_ready,
      input  req_ready, eng_start, eng_layer, eng_relu_en, buf_sel,
             resp_valid, resp_id, resp_error, busy
   );

   // The scheduler itself.
   modport slave (
      input  req_valid, eng_done, resp_ready,
      output req_ready, eng_start, eng_layer, eng_relu_en, buf_sel,
             resp_valid, resp_id, resp_error, busy
   );

endinterface

// File: rtl/nn_layer_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping.
module rr_arbiter
   import nn_layer_scheduler_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = clog2_min1(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i_req,
   input  logic             i_update,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_idx;
   logic             w_found;

   always_comb begin
      int j;
      j       = 0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(r_ptr) + k;
         if (j >= N) j = j - N;
         if (!w_found && i_req[j]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(j);
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign o_grant[gi] = w_found && (w_idx == IDX_W'(gi));
   end

   assign o_grant_idx = w_idx;
   assign o_any       = w_found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_update) begin
         r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/nn_layer_scheduler.sv
// Runs each granted job through NUM_LAYERS passes of the shared dense engine and reports completion.
module nn_layer_scheduler
   import nn_layer_scheduler_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int NUM_LAYERS     = 2,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int REQ_W          = clog2_min1(NUM_REQ),
   parameter int LAYER_W        = clog2_min1(NUM_LAYERS)
) (
   input logic                clk,
   input logic                rst,
   nn_layer_scheduler_if.slave bus
);

   localparam int                 CNT_W      = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]   TIMEOUT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
   localparam logic               FIRST_RELU = (NUM_LAYERS > 1);

   state_t             r_state, w_state_next;
   logic [NUM_REQ-1:0] r_ready, w_ready_next;
   logic               r_start, w_start_next;
   logic [LAYER_W-1:0] r_layer, w_layer_next;
   logic               r_relu, w_relu_next;
   logic               r_buf, w_buf_next;
   logic               r_resp_valid, w_resp_valid_next;
   logic [REQ_W-1:0]   r_resp_id, w_resp_id_next;
   logic               r_resp_err, w_resp_err_next;
   logic               r_busy, w_busy_next;
   logic [CNT_W-1:0]   r_cnt, w_cnt_next;
   logic [REQ_W-1:0]   r_id, w_id_next;

   logic [NUM_REQ-1:0] w_grant;
   logic [REQ_W-1:0]   w_grant_idx;
   logic               w_any;
   logic               w_grant_en;
   logic [LAYER_W-1:0] w_layer_inc;

   assign w_grant_en  = (r_state == ST_IDLE) && w_any;
   assign w_layer_inc = r_layer + LAYER_W'(1);

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (REQ_W)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (bus.req_valid),
      .i_update    (w_grant_en),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any)
   );

   always_comb begin
      w_state_next      = r_state;
      w_ready_next      = '0;
      w_start_next      = 1'b0;
      w_layer_next      = r_layer;
      w_relu_next       = r_relu;
      w_buf_next        = r_buf;
      w_resp_valid_next = r_resp_valid;
      w_resp_id_next    = r_resp_id;
      w_resp_err_next   = r_resp_err;
      w_cnt_next        = r_cnt;
      w_id_next         = r_id;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_next = ST_LAUNCH;
               w_ready_next = w_grant;
               w_start_next = 1'b1;
               w_layer_next = '0;
               w_relu_next  = FIRST_RELU;
               w_buf_next   = 1'b0;
               w_id_next    = w_grant_idx;
            end
         end
         ST_LAUNCH: begin
            w_state_next = ST_WAIT;
            w_cnt_next   = '0;
         end
         ST_WAIT: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            // Completion takes priority over a timeout landing in the same cycle.
            if (bus.eng_done) begin
               if (r_layer != LAST_LAYER) begin
                  w_state_next = ST_LAUNCH;
                  w_start_next = 1'b1;
                  w_layer_next = w_layer_inc;
                  w_relu_next  = (w_layer_inc != LAST_LAYER);
                  w_buf_next   = ~r_buf;
               end else begin
                  w_state_next      = ST_RESP;
                  w_resp_valid_next = 1'b1;
                  w_resp_id_next    = r_id;
                  w_resp_err_next   = 1'b0;
               end
            end else if (r_cnt == TIMEOUT_M1) begin
               w_state_next      = ST_RESP;
               w_resp_valid_next = 1'b1;
               w_resp_id_next    = r_id;
               w_resp_err_next   = 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               w_state_next      = ST_IDLE;
               w_resp_valid_next = 1'b0;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      w_busy_next = (w_state_next != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_ready      <= '0;
         r_start      <= 1'b0;
         r_layer      <= '0;
         r_relu       <= 1'b0;
         r_buf        <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
         r_resp_err   <= 1'b0;
         r_busy       <= 1'b0;
         r_cnt        <= '0;
         r_id         <= '0;
      end else begin
         r_state      <= w_state_next;
         r_ready      <= w_ready_next;
         r_start      <= w_start_next;
         r_layer      <= w_layer_next;
         r_relu       <= w_relu_next;
         r_buf        <= w_buf_next;
         r_resp_valid <= w_resp_valid_next;
         r_resp_id    <= w_resp_id_next;
         r_resp_err   <= w_resp_err_next;
         r_busy       <= w_busy_next;
         r_cnt        <= w_cnt_next;
         r_id         <= w_id_next;
      end
   end

   assign bus.req_ready   = r_ready;
   assign bus.eng_start   = r_start;
   assign bus.eng_layer   = r_layer;
   assign bus.eng_relu_en = r_relu;
   assign bus.buf_sel     = r_buf;
   assign bus.resp_valid  = r_resp_valid;
   assign bus.resp_id     = r_resp_id;
   assign bus.resp_error  = r_resp_err;
   assign bus.busy        = r_busy;

endmodule
